// File: rtl/board_pkg.sv
// Default board geometry, tile index type and move FSM state encoding shared by
// player_move_ctrl and tile_to_xy.
package board_pkg;
  localparam int DEFAULT_COLS        = 8;
  localparam int DEFAULT_ROWS        = 4;
  localparam int DEFAULT_TILE_W      = 32;
  localparam int DEFAULT_TILE_H      = 32;
  localparam int DEFAULT_ORIGIN_X    = 64;
  localparam int DEFAULT_ORIGIN_Y    = 96;
  localparam int DEFAULT_STEP_FRAMES = 8;
  localparam int DEFAULT_HOP_PX      = 4;

  localparam int DEFAULT_TILE_COUNT  = DEFAULT_COLS * DEFAULT_ROWS;
  localparam int DEFAULT_IDX_W       = $clog2(DEFAULT_TILE_COUNT);

  typedef logic [DEFAULT_IDX_W-1:0] tile_idx_t;

  typedef enum logic [1:0] {IDLE, LIFT, LAND, DONE} move_state_t;
endpackage

// File: rtl/tile_to_xy.sv
// Combinational tile index -> sprite top-left pixel position on the serpentine
// board (row 0 at the bottom, odd rows run right-to-left). 16x16 sprite centred.
module tile_to_xy
  import board_pkg::*;
#(
  parameter int COLS     = DEFAULT_COLS,
  parameter int ROWS     = DEFAULT_ROWS,
  parameter int TILE_W   = DEFAULT_TILE_W,
  parameter int TILE_H   = DEFAULT_TILE_H,
  parameter int ORIGIN_X = DEFAULT_ORIGIN_X,
  parameter int ORIGIN_Y = DEFAULT_ORIGIN_Y,
  parameter int IDX_W    = DEFAULT_IDX_W
) (
  input  logic [IDX_W-1:0] idx,
  output logic [9:0]       x,
  output logic [9:0]       y
);
  logic [9:0] idx_w;
  logic [9:0] row;
  logic [9:0] col_raw;
  logic [9:0] col;

  always_comb begin
    idx_w   = 10'(idx);
    row     = idx_w / 10'(COLS);
    col_raw = idx_w % 10'(COLS);
    col     = row[0] ? (10'(COLS - 1) - col_raw) : col_raw;
    x       = 10'(ORIGIN_X) + col * 10'(TILE_W) + 10'((TILE_W - 16) / 2);
    y       = 10'(ORIGIN_Y) + (10'(ROWS - 1) - row) * 10'(TILE_H) + 10'((TILE_H - 16) / 2);
  end
endmodule

// File: rtl/player_move_ctrl.sv
// Player token move sequencer: one request at a time, two-phase hop per tile paced by
// frame_tick. Optional macro SHARED_TILE_OFFSET_EN splits sprites sharing a tile.
//
// Handshake: a request transfers on a clock edge where move_valid && move_ready;
// move_ready is high only in IDLE, and requests presented while busy are dropped.
module player_move_ctrl
  import board_pkg::*;
#(
  parameter int COLS        = DEFAULT_COLS,
  parameter int ROWS        = DEFAULT_ROWS,
  parameter int TILE_W      = DEFAULT_TILE_W,
  parameter int TILE_H      = DEFAULT_TILE_H,
  parameter int ORIGIN_X    = DEFAULT_ORIGIN_X,
  parameter int ORIGIN_Y    = DEFAULT_ORIGIN_Y,
  parameter int STEP_FRAMES = DEFAULT_STEP_FRAMES,
  parameter int HOP_PX      = DEFAULT_HOP_PX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic       move_player,
  input  logic [3:0] move_steps,
  output logic       busy,
  output logic       move_done,
  output logic       goal_reached,
  output logic [9:0] p0_x,
  output logic [9:0] p0_y,
  output logic [9:0] p1_x,
  output logic [9:0] p1_y
);
  localparam int TILE_COUNT = COLS * ROWS;
  localparam int LAST       = TILE_COUNT - 1;
  localparam int IDX_W      = $clog2(TILE_COUNT);
  localparam int SW         = (IDX_W > 4) ? IDX_W : 4;
  localparam int HALF       = STEP_FRAMES / 2;
  localparam int FW         = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [9:0] RST_X = 10'(ORIGIN_X + (TILE_W - 16) / 2);
  localparam logic [9:0] RST_Y = 10'(ORIGIN_Y + (ROWS - 1) * TILE_H + (TILE_H - 16) / 2);

  move_state_t      state, state_next;
  logic [IDX_W-1:0] idx0, idx1, mover_idx, req_idx;
  logic             mover;
  logic [SW-1:0]    steps_left, remaining, clamp;
  logic [FW-1:0]    frame_cnt;
  logic             accept, phase_end;
  logic [9:0]       x0, y0, x1, y1;
  logic [9:0]       x0_o, y0_o, x1_o, y1_o;

  assign accept    = move_valid && move_ready;
  assign phase_end = frame_tick && (frame_cnt == FW'(HALF - 1));
  assign mover_idx = mover ? idx1 : idx0;
  assign req_idx   = move_player ? idx1 : idx0;
  assign remaining = SW'(LAST) - SW'(req_idx);
  assign clamp     = (SW'(move_steps) > remaining) ? remaining : SW'(move_steps);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (clamp != '0) ? LIFT : DONE;
      LIFT: if (phase_end) state_next = LAND;
      LAND: if (phase_end) state_next = (steps_left > SW'(1)) ? LIFT : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    move_ready   = (state == IDLE);
    busy         = (state != IDLE);
    move_done    = (state == DONE);
    goal_reached = (state == DONE) && (mover_idx == IDX_W'(LAST));
  end

  // Frame counter restarts on every phase change, so the accept-cycle tick is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx0       <= '0;
      idx1       <= '0;
      mover      <= 1'b0;
      steps_left <= '0;
      frame_cnt  <= '0;
    end else begin
      if (state != state_next)
        frame_cnt <= '0;
      else if (frame_tick && (state == LIFT || state == LAND))
        frame_cnt <= frame_cnt + FW'(1);
      if (accept) begin
        mover      <= move_player;
        steps_left <= clamp;
      end
      if (state == LIFT && phase_end) begin
        if (mover) idx1 <= idx1 + IDX_W'(1);
        else       idx0 <= idx0 + IDX_W'(1);
      end
      if (state == LAND && phase_end)
        steps_left <= steps_left - SW'(1);
    end
  end

  tile_to_xy #(
    .COLS(COLS), .ROWS(ROWS), .TILE_W(TILE_W), .TILE_H(TILE_H),
    .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y), .IDX_W(IDX_W)
  ) u_xy0 (.idx(idx0), .x(x0), .y(y0));

  tile_to_xy #(
    .COLS(COLS), .ROWS(ROWS), .TILE_W(TILE_W), .TILE_H(TILE_H),
    .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y), .IDX_W(IDX_W)
  ) u_xy1 (.idx(idx1), .x(x1), .y(y1));

  always_comb begin
    y0_o = y0 - ((state == LIFT && !mover) ? 10'(HOP_PX) : 10'd0);
    y1_o = y1 - ((state == LIFT &&  mover) ? 10'(HOP_PX) : 10'd0);
`ifdef SHARED_TILE_OFFSET_EN
    if (idx0 == idx1) begin
      x0_o = x0 - 10'd4;
      x1_o = x1 + 10'd8;
    end else begin
      x0_o = x0;
      x1_o = x1;
    end
`else
    x0_o = x0;
    x1_o = x1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef SHARED_TILE_OFFSET_EN
      p0_x <= RST_X - 10'd4;
      p1_x <= RST_X + 10'd8;
`else
      p0_x <= RST_X;
      p1_x <= RST_X;
`endif
      p0_y <= RST_Y;
      p1_y <= RST_Y;
    end else begin
      p0_x <= x0_o;
      p0_y <= y0_o;
      p1_x <= x1_o;
      p1_y <= y1_o;
    end
  end
endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl at default board parameters: a move table with
// hand-computed tick counts and landing coordinates, plus multi-cycle corner sequences.
module tb_player_move_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       move_valid = 1'b0;
  logic       move_ready;
  logic       move_player = 1'b0;
  logic [3:0] move_steps = 4'd0;
  logic       busy, move_done, goal_reached;
  logic [9:0] p0_x, p0_y, p1_x, p1_y;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pl;
    logic [3:0] st;
    int         ticks;
    int         x;
    int         y;
    logic       goal;
  } vec_t;

  vec_t vecs[10];
  int   exp_x[2];
  int   exp_y[2];

  player_move_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_player(move_player), .move_steps(move_steps),
    .busy(busy), .move_done(move_done), .goal_reached(goal_reached),
    .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_tick = 1'b0;
    move_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    exp_x[0] = 72; exp_y[0] = 200;
    exp_x[1] = 72; exp_y[1] = 200;
  endtask

  task automatic accept(input logic pl, input logic [3:0] st);
    move_valid  = 1'b1;
    move_player = pl;
    move_steps  = st;
    cyc();
    move_valid  = 1'b0;
  endtask

  // Ticks every other cycle until move_done is seen; reports ticks delivered before it.
  task automatic wait_done(output int ticks, output logic goal, output logic ok);
    ticks = 0;
    goal  = 1'b0;
    ok    = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      if (move_done) begin
        ok   = 1'b1;
        goal = goal_reached;
      end else begin
        frame_tick = (c % 2 == 0);
        cyc();
        if (frame_tick) ticks++;
        frame_tick = 1'b0;
      end
    end
  endtask

  task automatic chk_coords(input string tag);
    chk({tag, " p0_x"}, 32'(p0_x), exp_x[0]);
    chk({tag, " p0_y"}, 32'(p0_y), exp_y[0]);
    chk({tag, " p1_x"}, 32'(p1_x), exp_x[1]);
    chk({tag, " p1_y"}, 32'(p1_y), exp_y[1]);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int   ticks;
    logic goal, ok;
    string tag;
    tag = $sformatf("vec%0d", n);
    chk({tag, " ready"}, 32'(move_ready), 1);
    accept(v.pl, v.st);
    chk({tag, " busy"}, 32'(busy), 1);
    wait_done(ticks, goal, ok);
    chk({tag, " done_seen"}, 32'(ok), 1);
    chk({tag, " ticks"}, ticks, v.ticks);
    chk({tag, " goal"}, 32'(goal), 32'(v.goal));
    exp_x[v.pl] = v.x;
    exp_y[v.pl] = v.y;
    chk_coords({tag, " at_done"});
    cyc();
    chk({tag, " done_one_cycle"}, 32'(move_done), 0);
    chk({tag, " ready_after"}, 32'(move_ready), 1);
  endtask

  initial begin
    int   ticks;
    int   done_cnt;
    logic goal, ok;

    //          pl    st     ticks x    y    goal
    vecs[0] = '{1'b1, 4'd7,  56,  296, 200, 1'b0};
    vecs[1] = '{1'b1, 4'd1,  8,   296, 168, 1'b0};
    vecs[2] = '{1'b0, 4'd15, 120, 136, 136, 1'b0};
    vecs[3] = '{1'b0, 4'd0,  0,   136, 136, 1'b0};
    vecs[4] = '{1'b0, 4'd15, 104, 72,  104, 1'b1};
    vecs[5] = '{1'b0, 4'd2,  0,   72,  104, 1'b1};
    vecs[6] = '{1'b1, 4'd15, 120, 296, 136, 1'b0};
    vecs[7] = '{1'b1, 4'd6,  48,  136, 104, 1'b0};
    vecs[8] = '{1'b1, 4'd5,  16,  72,  104, 1'b1};
    vecs[9] = '{1'b1, 4'd3,  0,   72,  104, 1'b1};

    // Reset state
    do_reset();
    chk_coords("reset");
    chk("reset ready", 32'(move_ready), 1);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(move_done), 0);
    chk("reset goal", 32'(goal_reached), 0);

    // P0 three steps, including the lift in the first phase
    accept(1'b0, 4'd3);
    chk("p0_3 busy", 32'(busy), 1);
    chk("p0_3 ready", 32'(move_ready), 0);
    cyc();
    chk("p0_3 lift_y", 32'(p0_y), 196);
    chk("p0_3 lift_x", 32'(p0_x), 72);
    chk("p0_3 p1_y static", 32'(p1_y), 200);
    wait_done(ticks, goal, ok);
    chk("p0_3 done_seen", 32'(ok), 1);
    chk("p0_3 ticks", ticks, 24);
    chk("p0_3 goal", 32'(goal), 0);
    exp_x[0] = 168;
    chk_coords("p0_3");
    cyc();
    chk("p0_3 done_one_cycle", 32'(move_done), 0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Requests while busy are dropped
    do_reset();
    accept(1'b0, 4'd4);
    move_valid  = 1'b1;
    move_player = 1'b1;
    move_steps  = 4'd7;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("busy_drop ready%0d", i), 32'(move_ready), 0);
      cyc();
    end
    move_valid = 1'b0;
    wait_done(ticks, goal, ok);
    chk("busy_drop done_seen", 32'(ok), 1);
    chk("busy_drop ticks", ticks, 32);
    exp_x[0] = 200;
    chk_coords("busy_drop");
    cyc();
    chk("busy_drop idle", 32'(busy), 0);
    chk_coords("busy_drop after");

    // Zero-step request: done in the cycle after accept, no motion, no goal
    accept(1'b1, 4'd0);
    chk("zero done", 32'(move_done), 1);
    chk("zero goal", 32'(goal_reached), 0);
    chk("zero busy", 32'(busy), 1);
    cyc();
    chk("zero done_low", 32'(move_done), 0);
    chk("zero ready", 32'(move_ready), 1);
    chk_coords("zero");

    // Reset at tick 10 of an 8-step move
    accept(1'b1, 4'd8);
    for (int t = 0; t < 10; t++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
    chk("abort pre p1_x", 32'(p1_x), 104);
    chk("abort pre p1_y", 32'(p1_y), 196);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_x[0] = 72; exp_y[0] = 200;
    exp_x[1] = 72; exp_y[1] = 200;
    chk_coords("abort");
    chk("abort busy", 32'(busy), 0);
    chk("abort ready", 32'(move_ready), 1);
    chk("abort done", 32'(move_done), 0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      frame_tick = (c % 2 == 0);
      cyc();
      frame_tick = 1'b0;
      if (move_done) done_cnt++;
    end
    chk("abort no_done", done_cnt, 0);
    chk_coords("abort settle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
